ctrl_cfg_writer: RTL and testbench

CTRL_CFG_WRITER -- requirements
Module: ctrl_cfg_writer

---
 rtl/ctrl_cfg_writer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ctrl_cfg_writer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_cfg_writer.sv
// ----------------------------------------------------------------------------
// ctrl_cfg_writer
//   Turns control packets from the parser's control stream into a sequence of
//   128-bit configuration writes. Beat 0 carries the header (target module,
//   start index, opcode) and one data word. Each later beat carries up to four
//   words. Words are emitted one per cfg_wr handshake, and the address
//   increments for every word across the whole packet.
//
// Ports
//   clk, areset            : single clock, asynchronous active-high reset
//   c_s_axis_*             : 512-bit control-packet stream input (tuser unused)
//   c_s_axis_tready        : registered back-pressure, low while emitting
//   cfg_wr_valid/ready     : config write handshake
//   cfg_wr_mod_id/addr/    : target module, entry address, entry data,
//   cfg_wr_data/last         last word of packet
//   stat_pkt_cnt           : completed packets (saturating)
//   stat_drop_cnt          : dropped packets (saturating)
// ----------------------------------------------------------------------------
module ctrl_cfg_writer #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                               clk,
    input  logic                               areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     c_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   c_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    c_s_axis_tuser,
    input  logic                               c_s_axis_tvalid,
    input  logic                               c_s_axis_tlast,
    output logic                               c_s_axis_tready,
    output logic                               cfg_wr_valid,
    input  logic                               cfg_wr_ready,
    output logic [15:0]                        cfg_wr_mod_id,
    output logic [7:0]                         cfg_wr_addr,
    output logic [127:0]                       cfg_wr_data,
    output logic                               cfg_wr_last,
    output logic [31:0]                        stat_pkt_cnt,
    output logic [31:0]                        stat_drop_cnt
);

    localparam int NUM_LANES = 4;
    localparam int WORD_W    = 128;
    localparam int KEEP_W    = WORD_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_WAIT,
        S_DROP
    } state_e;

    // Lowest set lane of a mask; callers only use the result when mask != 0.
    function automatic logic [1:0] first_lane(input logic [NUM_LANES-1:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    function automatic logic [NUM_LANES-1:0] lane_bit(input logic [1:0] lane);
        return NUM_LANES'(1) << lane;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    // ------------------------------------------------------------------
    // Stream decode
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]    lane_word [NUM_LANES];
    logic [NUM_LANES-1:0] lane_keep;

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_word[l] = c_s_axis_tdata[l*WORD_W +: WORD_W];
            lane_keep[l] = &c_s_axis_tkeep[l*KEEP_W +: KEEP_W];
        end
    end

    logic [15:0] beat0_mod_id;
    logic [7:0]  beat0_index;
    logic [7:0]  beat0_op;
    logic        beat0_ok;

    assign beat0_mod_id = c_s_axis_tdata[351:336];
    assign beat0_index  = c_s_axis_tdata[359:352];
    assign beat0_op     = c_s_axis_tdata[367:360];
    assign beat0_ok     = (beat0_op == 8'h01) && (&c_s_axis_tkeep[47:0]);

    // tuser is carried by the stream but has no meaning for config writes.
    logic unused_tuser;
    assign unused_tuser = ^c_s_axis_tuser;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic                 tready_q, tready_d;
    logic                 valid_q, valid_d;
    logic [15:0]          mod_id_q, mod_id_d;
    logic [7:0]           addr_q, addr_d;
    logic [127:0]         data_q, data_d;
    logic                 last_q, last_d;
    logic [7:0]           next_addr_q, next_addr_d;   // address of the next word to load
    logic [NUM_LANES-1:0] pend_q, pend_d;             // buffered lanes not yet presented
    logic                 buf_last_q, buf_last_d;     // buffered beat carried tlast
    logic [31:0]          pkt_cnt_q, pkt_cnt_d;
    logic [31:0]          drop_cnt_q, drop_cnt_d;
    logic [WORD_W-1:0]    buf_word_q [NUM_LANES];
    logic [WORD_W-1:0]    buf_word_d [NUM_LANES];

    logic                 accept;
    logic                 beat_load;
    logic [NUM_LANES-1:0] beat_mask;
    logic [7:0]           beat_base;
    logic [1:0]           beat_lane;
    logic [NUM_LANES-1:0] beat_rest;
    logic [1:0]           emit_lane;
    logic [NUM_LANES-1:0] emit_rest;

    assign accept = c_s_axis_tvalid && tready_q;

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d     = state_q;
        valid_d     = valid_q;
        mod_id_d    = mod_id_q;
        addr_d      = addr_q;
        data_d      = data_q;
        last_d      = last_q;
        next_addr_d = next_addr_q;
        pend_d      = pend_q;
        buf_last_d  = buf_last_q;
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        buf_word_d  = buf_word_q;
        beat_load   = 1'b0;
        beat_mask   = '0;
        beat_base   = next_addr_q;
        beat_lane   = 2'd0;
        beat_rest   = '0;
        emit_lane   = first_lane(pend_q);
        emit_rest   = pend_q & ~lane_bit(first_lane(pend_q));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (beat0_ok) begin
                        mod_id_d  = beat0_mod_id;
                        beat_load = 1'b1;
                        beat_mask = {lane_keep[3], 3'b000};  // word 0 sits in lane 3
                        beat_base = beat0_index;
                    end else begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        state_d    = c_s_axis_tlast ? S_IDLE : S_DROP;
                    end
                end
            end
            S_WAIT: begin
                if (accept) begin
                    beat_load = 1'b1;
                    beat_mask = lane_keep;
                end
            end
            S_EMIT: begin
                if (valid_q && cfg_wr_ready) begin
                    if (pend_q != '0) begin
                        // Next buffered word goes out straight away, skipping holes.
                        data_d      = buf_word_q[emit_lane];
                        addr_d      = next_addr_q;
                        next_addr_d = next_addr_q + 8'd1;
                        last_d      = buf_last_q && (emit_rest == '0);
                        pend_d      = emit_rest;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = buf_last_q ? S_IDLE : S_WAIT;
                    end
                end
            end
            S_DROP: begin
                if (accept && c_s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (beat_load) begin
            buf_word_d  = lane_word;
            buf_last_d  = c_s_axis_tlast;
            next_addr_d = beat_base;
            if (c_s_axis_tlast) begin
                pkt_cnt_d = sat_inc(pkt_cnt_q);
            end
            if (beat_mask != '0) begin
                // First valid word is presented the cycle after acceptance.
                beat_lane   = first_lane(beat_mask);
                beat_rest   = beat_mask & ~lane_bit(first_lane(beat_mask));
                valid_d     = 1'b1;
                data_d      = lane_word[beat_lane];
                addr_d      = beat_base;
                next_addr_d = beat_base + 8'd1;
                last_d      = c_s_axis_tlast && (beat_rest == '0);
                pend_d      = beat_rest;
                state_d     = S_EMIT;
            end else begin
                // A beat with no usable words writes nothing.
                state_d = c_s_axis_tlast ? S_IDLE : S_WAIT;
            end
        end

        tready_d = (state_d != S_EMIT);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            tready_q    <= 1'b0;
            valid_q     <= 1'b0;
            mod_id_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            next_addr_q <= '0;
            pend_q      <= '0;
            buf_last_q  <= 1'b0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tready_q    <= tready_d;
            valid_q     <= valid_d;
            mod_id_q    <= mod_id_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            last_q      <= last_d;
            next_addr_q <= next_addr_d;
            pend_q      <= pend_d;
            buf_last_q  <= buf_last_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // NOTE: the word buffer has no reset; pend_q clearing on reset is what
    // discards its contents, so stale data can never be presented.
    always_ff @(posedge clk) begin
        buf_word_q <= buf_word_d;
    end

    assign c_s_axis_tready = tready_q;
    assign cfg_wr_valid    = valid_q;
    assign cfg_wr_mod_id   = mod_id_q;
    assign cfg_wr_addr     = addr_q;
    assign cfg_wr_data     = data_q;
    assign cfg_wr_last     = last_q;
    assign stat_pkt_cnt    = pkt_cnt_q;
    assign stat_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ctrl_cfg_writer.sv
// ----------------------------------------------------------------------------
// tb_ctrl_cfg_writer
//   Directed bench for ctrl_cfg_writer. Inputs are driven 1 time unit after
//   the rising edge; a negedge monitor records every cfg_wr handshake and
//   watches that stalled words stay stable. Each scenario task compares the
//   recorded writes and counters with hand-derived values.
// ----------------------------------------------------------------------------
module tb_ctrl_cfg_writer;

    logic         clk;
    logic         areset;
    logic [511:0] c_s_axis_tdata;
    logic [63:0]  c_s_axis_tkeep;
    logic [127:0] c_s_axis_tuser;
    logic         c_s_axis_tvalid;
    logic         c_s_axis_tlast;
    logic         c_s_axis_tready;
    logic         cfg_wr_valid;
    logic         cfg_wr_ready;
    logic [15:0]  cfg_wr_mod_id;
    logic [7:0]   cfg_wr_addr;
    logic [127:0] cfg_wr_data;
    logic         cfg_wr_last;
    logic [31:0]  stat_pkt_cnt;
    logic [31:0]  stat_drop_cnt;

    int total = 0;
    int bad   = 0;
    int exp_pkt  = 0;
    int exp_drop = 0;

    ctrl_cfg_writer #(
        .C_S_AXIS_DATA_WIDTH (512),
        .C_S_AXIS_TUSER_WIDTH(128)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .c_s_axis_tdata (c_s_axis_tdata),
        .c_s_axis_tkeep (c_s_axis_tkeep),
        .c_s_axis_tuser (c_s_axis_tuser),
        .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast (c_s_axis_tlast),
        .c_s_axis_tready(c_s_axis_tready),
        .cfg_wr_valid   (cfg_wr_valid),
        .cfg_wr_ready   (cfg_wr_ready),
        .cfg_wr_mod_id  (cfg_wr_mod_id),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .cfg_wr_last    (cfg_wr_last),
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_drop_cnt  (stat_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor: handshake capture, tready-low cycles, stability on stall
    // ------------------------------------------------------------------
    logic [7:0]   cap_addr [$];
    logic [127:0] cap_data [$];
    logic         cap_last [$];
    logic [15:0]  cap_mod  [$];
    int           cap_cyc  [$];
    int           cyc        = 0;
    int           tready_low = 0;
    int           hold_err   = 0;
    logic         prev_stall = 1'b0;
    logic [7:0]   held_addr  = '0;
    logic [127:0] held_data  = '0;
    logic         held_last  = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (!c_s_axis_tready) tready_low = tready_low + 1;
            if (prev_stall && (!cfg_wr_valid || cfg_wr_addr !== held_addr ||
                               cfg_wr_data !== held_data || cfg_wr_last !== held_last))
                hold_err = hold_err + 1;
            if (cfg_wr_valid && cfg_wr_ready) begin
                cap_addr.push_back(cfg_wr_addr);
                cap_data.push_back(cfg_wr_data);
                cap_last.push_back(cfg_wr_last);
                cap_mod.push_back(cfg_wr_mod_id);
                cap_cyc.push_back(cyc);
            end
            prev_stall = cfg_wr_valid && !cfg_wr_ready;
            held_addr  = cfg_wr_addr;
            held_data  = cfg_wr_data;
            held_last  = cfg_wr_last;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [127:0] wv(input int t, input int b, input int l);
        logic [7:0] tt, bb, ll;
        tt = t[7:0];
        bb = b[7:0];
        ll = l[7:0];
        return {16'hBEEF, tt, bb, ll, 88'h0011_2233_4455_6677_8899_AA};
    endfunction

    function automatic logic [511:0] mk_beat0(input logic [15:0] mod, input logic [7:0] idx,
                                              input logic [7:0] op, input logic [127:0] w0);
        logic [511:0] d;
        d = {64{8'hA5}};
        d[511:384] = w0;
        d[367:360] = op;
        d[359:352] = idx;
        d[351:336] = mod;
        return d;
    endfunction

    function automatic logic [511:0] mk_data(input int t, input int b);
        return {wv(t, b, 3), wv(t, b, 2), wv(t, b, 1), wv(t, b, 0)};
    endfunction

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
        bit accepted;
        accepted        = 1'b0;
        c_s_axis_tdata  = d;
        c_s_axis_tkeep  = k;
        c_s_axis_tlast  = l;
        c_s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (c_s_axis_tready) accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        c_s_axis_tvalid = 1'b0;
        if (!accepted) begin
            total++; bad++;
            $display("FAIL beat_accept got=tready_low_200_cycles exp=accepted");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!cfg_wr_valid && c_s_axis_tready) done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL drain_timeout got=busy exp=idle");
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (c_s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b exp=0", c_s_axis_tready); end
        total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", cfg_wr_valid); end
        total++; if (cfg_wr_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", cfg_wr_last); end
        total++; if ({cfg_wr_mod_id, cfg_wr_addr} !== 24'h0) begin bad++; $display("FAIL rst_mod_addr got=%h exp=0", {cfg_wr_mod_id, cfg_wr_addr}); end
        total++; if (cfg_wr_data !== 128'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", cfg_wr_data); end
        total++; if ({stat_pkt_cnt, stat_drop_cnt} !== 64'h0) begin bad++; $display("FAIL rst_counters got=%h exp=0", {stat_pkt_cnt, stat_drop_cnt}); end
        @(negedge clk);
        areset = 1'b0;
        #1;
        total++; if (c_s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_release_tready_early got=%b exp=0", c_s_axis_tready); end
        @(posedge clk);
        #1;
        total++; if (c_s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_release_tready got=%b exp=1", c_s_axis_tready); end
    endtask

    task automatic test_single();
        int n0;
        n0 = cap_addr.size();
        cfg_wr_ready = 1'b1;
        send_beat(mk_beat0(16'h0002, 8'h10, 8'h01, wv(1, 0, 3)), {64{1'b1}}, 1'b1);
        total++; if (cfg_wr_valid !== 1'b1) begin bad++; $display("FAIL single_latency got valid=%b exp=1", cfg_wr_valid); end
        wait_idle();
        exp_pkt++;
        total++; if (cap_addr.size() - n0 !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", cap_addr.size() - n0); end
        if (cap_addr.size() > n0) begin
            total++;
            if (cap_addr[n0] !== 8'h10 || cap_data[n0] !== wv(1, 0, 3) || cap_last[n0] !== 1'b1 || cap_mod[n0] !== 16'h0002) begin
                bad++;
                $display("FAIL single_word got addr=%h last=%b mod=%h data=%h exp addr=10 last=1 mod=0002 data=%h",
                         cap_addr[n0], cap_last[n0], cap_mod[n0], cap_data[n0], wv(1, 0, 3));
            end
        end
        total++; if (stat_pkt_cnt !== 32'(exp_pkt)) begin bad++; $display("FAIL single_pkt_cnt got=%0d exp=%0d", stat_pkt_cnt, exp_pkt); end
        total++; if (stat_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL single_drop_cnt got=%0d exp=%0d", stat_drop_cnt, exp_drop); end
    endtask

    task automatic test_multi();
        int           n0, t0;
        logic [7:0]   e_addr [9];
        logic [127:0] e_data [9];
        logic         e_last [9];
        for (int i = 0; i < 9; i++) begin
            e_addr[i] = 8'hFE + 8'(i);
            e_data[i] = (i == 0) ? wv(2, 0, 3) : wv(2, 1 + (i - 1) / 4, (i - 1) % 4);
            e_last[i] = (i == 8);
        end
        n0 = cap_addr.size();
        t0 = tready_low;
        cfg_wr_ready = 1'b1;
        send_beat(mk_beat0(16'h0033, 8'hFE, 8'h01, wv(2, 0, 3)), {64{1'b1}}, 1'b0);
        send_beat(mk_data(2, 1), {64{1'b1}}, 1'b0);
        send_beat(mk_data(2, 2), {64{1'b1}}, 1'b1);
        wait_idle();
        exp_pkt++;
        total++; if (cap_addr.size() - n0 !== 9) begin bad++; $display("FAIL multi_count got=%0d exp=9", cap_addr.size() - n0); end
        for (int i = 0; i < 9; i++) begin
            if (n0 + i < cap_addr.size()) begin
                total++;
                if (cap_addr[n0+i] !== e_addr[i] || cap_data[n0+i] !== e_data[i] ||
                    cap_last[n0+i] !== e_last[i] || cap_mod[n0+i] !== 16'h0033) begin
                    bad++;
                    $display("FAIL multi_word%0d got addr=%h last=%b mod=%h data=%h exp addr=%h last=%b mod=0033 data=%h",
                             i, cap_addr[n0+i], cap_last[n0+i], cap_mod[n0+i], cap_data[n0+i], e_addr[i], e_last[i], e_data[i]);
                end
            end
        end
        // one low cycle for the header word, four per full data beat
        total++; if (tready_low - t0 !== 9) begin bad++; $display("FAIL multi_tready_low got=%0d exp=9", tready_low - t0); end
        total++; if (stat_pkt_cnt !== 32'(exp_pkt)) begin bad++; $display("FAIL multi_pkt_cnt got=%0d exp=%0d", stat_pkt_cnt, exp_pkt); end
    endtask

    task automatic test_partial();
        int           n0;
        logic [7:0]   e_addr [8];
        logic [127:0] e_data [8];
        logic         e_last [8];
        e_addr = '{8'h30, 8'h31, 8'h32, 8'h50, 8'h51, 8'h52, 8'h53, 8'h60};
        e_data = '{wv(3, 0, 3), wv(3, 1, 0), wv(3, 1, 2),
                   wv(4, 1, 0), wv(4, 1, 1), wv(4, 1, 2), wv(4, 1, 3), wv(5, 0, 3)};
        e_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n0 = cap_addr.size();
        cfg_wr_ready = 1'b1;
        // lanes 1 and 3 of the data beat are partial and must be skipped
        send_beat(mk_beat0(16'h0A0A, 8'h30, 8'h01, wv(3, 0, 3)), {64{1'b1}}, 1'b0);
        send_beat(mk_data(3, 1), 64'h0000_FFFF_0000_FFFF, 1'b1);
        wait_idle();
        // header word 0 incomplete: no write for beat 0, addressing starts at index
        send_beat(mk_beat0(16'h0B0B, 8'h50, 8'h01, wv(4, 0, 3)), 64'h0000_FFFF_FFFF_FFFF, 1'b0);
        send_beat(mk_data(4, 1), {64{1'b1}}, 1'b1);
        wait_idle();
        // tlast beat with no valid words: the earlier word keeps last=0
        send_beat(mk_beat0(16'h0C0C, 8'h60, 8'h01, wv(5, 0, 3)), {64{1'b1}}, 1'b0);
        send_beat(mk_data(5, 1), 64'h0, 1'b1);
        wait_idle();
        exp_pkt += 3;
        total++; if (cap_addr.size() - n0 !== 8) begin bad++; $display("FAIL partial_count got=%0d exp=8", cap_addr.size() - n0); end
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < cap_addr.size()) begin
                total++;
                if (cap_addr[n0+i] !== e_addr[i] || cap_data[n0+i] !== e_data[i] || cap_last[n0+i] !== e_last[i]) begin
                    bad++;
                    $display("FAIL partial_word%0d got addr=%h last=%b data=%h exp addr=%h last=%b data=%h",
                             i, cap_addr[n0+i], cap_last[n0+i], cap_data[n0+i], e_addr[i], e_last[i], e_data[i]);
                end
            end
        end
        if (cap_addr.size() >= n0 + 3) begin
            total++;
            if (cap_cyc[n0+2] - cap_cyc[n0+1] !== 1) begin
                bad++;
                $display("FAIL partial_no_bubble got gap=%0d exp=1", cap_cyc[n0+2] - cap_cyc[n0+1]);
            end
        end
        total++; if (stat_pkt_cnt !== 32'(exp_pkt)) begin bad++; $display("FAIL partial_pkt_cnt got=%0d exp=%0d", stat_pkt_cnt, exp_pkt); end
    endtask

    task automatic test_drop();
        int n0, t0;
        n0 = cap_addr.size();
        t0 = tready_low;
        cfg_wr_ready = 1'b1;
        send_beat(mk_beat0(16'h0D0D, 8'h00, 8'h02, wv(6, 0, 3)), {64{1'b1}}, 1'b0);
        send_beat(mk_data(6, 1), {64{1'b1}}, 1'b0);
        send_beat(mk_data(6, 2), {64{1'b1}}, 1'b0);
        send_beat(mk_data(6, 3), {64{1'b1}}, 1'b1);
        wait_idle();
        exp_drop++;
        total++; if (cap_addr.size() - n0 !== 0) begin bad++; $display("FAIL drop_op_writes got=%0d exp=0", cap_addr.size() - n0); end
        total++; if (tready_low - t0 !== 0) begin bad++; $display("FAIL drop_op_tready_low got=%0d exp=0", tready_low - t0); end
        total++; if (stat_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL drop_op_cnt got=%0d exp=%0d", stat_drop_cnt, exp_drop); end
        total++; if (stat_pkt_cnt !== 32'(exp_pkt)) begin bad++; $display("FAIL drop_op_pkt_cnt got=%0d exp=%0d", stat_pkt_cnt, exp_pkt); end
        // correct opcode but incomplete header keep also drops
        send_beat(mk_beat0(16'h0E0E, 8'h00, 8'h01, wv(6, 4, 3)), 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        send_beat(mk_data(6, 5), {64{1'b1}}, 1'b1);
        wait_idle();
        exp_drop++;
        total++; if (cap_addr.size() - n0 !== 0) begin bad++; $display("FAIL drop_keep_writes got=%0d exp=0", cap_addr.size() - n0); end
        total++; if (stat_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL drop_keep_cnt got=%0d exp=%0d", stat_drop_cnt, exp_drop); end
        // the next packet is parsed from its own header
        send_beat(mk_beat0(16'h0F0F, 8'h70, 8'h01, wv(6, 6, 3)), {64{1'b1}}, 1'b1);
        wait_idle();
        exp_pkt++;
        total++; if (cap_addr.size() - n0 !== 1) begin bad++; $display("FAIL drop_recover_count got=%0d exp=1", cap_addr.size() - n0); end
        if (cap_addr.size() > n0) begin
            total++;
            if (cap_addr[n0] !== 8'h70 || cap_data[n0] !== wv(6, 6, 3) || cap_mod[n0] !== 16'h0F0F) begin
                bad++;
                $display("FAIL drop_recover_word got addr=%h mod=%h exp addr=70 mod=0F0F", cap_addr[n0], cap_mod[n0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n0, h0;
        n0 = cap_addr.size();
        h0 = hold_err;
        cfg_wr_ready = 1'b0;
        fork
            begin
                send_beat(mk_beat0(16'h0BAD, 8'h40, 8'h01, wv(7, 0, 3)), {64{1'b1}}, 1'b0);
                send_beat(mk_data(7, 1), {64{1'b1}}, 1'b1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    cfg_wr_ready = ~cfg_wr_ready;
                end
            end
        join
        cfg_wr_ready = 1'b1;
        wait_idle();
        exp_pkt++;
        total++; if (hold_err - h0 !== 0) begin bad++; $display("FAIL bp_hold got=%0d_changes exp=0", hold_err - h0); end
        total++; if (cap_addr.size() - n0 !== 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", cap_addr.size() - n0); end
        for (int i = 0; i < 5; i++) begin
            if (n0 + i < cap_addr.size()) begin
                total++;
                if (cap_addr[n0+i] !== 8'h40 + 8'(i) ||
                    cap_data[n0+i] !== ((i == 0) ? wv(7, 0, 3) : wv(7, 1, i - 1)) ||
                    cap_last[n0+i] !== (i == 4)) begin
                    bad++;
                    $display("FAIL bp_word%0d got addr=%h last=%b data=%h exp addr=%h last=%b",
                             i, cap_addr[n0+i], cap_last[n0+i], cap_data[n0+i], 8'h40 + 8'(i), (i == 4));
                end
            end
        end
        total++; if (stat_pkt_cnt !== 32'(exp_pkt)) begin bad++; $display("FAIL bp_pkt_cnt got=%0d exp=%0d", stat_pkt_cnt, exp_pkt); end
    endtask

    task automatic test_reset_mid();
        int n0;
        cfg_wr_ready = 1'b1;
        send_beat(mk_beat0(16'h0C0C, 8'h80, 8'h01, wv(8, 0, 3)), {64{1'b1}}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cfg_wr_ready = 1'b0;
        send_beat(mk_data(8, 1), {64{1'b1}}, 1'b0);
        @(posedge clk);
        #1;
        cfg_wr_ready = 1'b1;
        @(posedge clk);
        #1;
        cfg_wr_ready = 1'b0;
        total++; if (cfg_wr_valid !== 1'b1 || cfg_wr_addr !== 8'h82) begin bad++; $display("FAIL rmid_pre got valid=%b addr=%h exp valid=1 addr=82", cfg_wr_valid, cfg_wr_addr); end
        areset = 1'b1;
        #1;
        total++; if (cfg_wr_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", cfg_wr_valid); end
        total++; if (c_s_axis_tready !== 1'b0 || cfg_wr_addr !== 8'h00) begin bad++; $display("FAIL rmid_state got tready=%b addr=%h exp tready=0 addr=00", c_s_axis_tready, cfg_wr_addr); end
        total++; if (stat_pkt_cnt !== 32'h0) begin bad++; $display("FAIL rmid_pkt_clear got=%0d exp=0", stat_pkt_cnt); end
        @(negedge clk);
        areset = 1'b0;
        cfg_wr_ready = 1'b1;
        exp_pkt  = 0;
        exp_drop = 0;
        n0 = cap_addr.size();
        send_beat(mk_beat0(16'h0D0D, 8'h20, 8'h01, wv(9, 0, 3)), {64{1'b1}}, 1'b1);
        wait_idle();
        exp_pkt++;
        total++; if (cap_addr.size() - n0 !== 1) begin bad++; $display("FAIL rmid_count got=%0d exp=1", cap_addr.size() - n0); end
        if (cap_addr.size() > n0) begin
            total++;
            if (cap_addr[n0] !== 8'h20 || cap_data[n0] !== wv(9, 0, 3) || cap_last[n0] !== 1'b1 || cap_mod[n0] !== 16'h0D0D) begin
                bad++;
                $display("FAIL rmid_word got addr=%h last=%b mod=%h data=%h exp addr=20 last=1 mod=0D0D data=%h",
                         cap_addr[n0], cap_last[n0], cap_mod[n0], cap_data[n0], wv(9, 0, 3));
            end
        end
        total++; if (stat_pkt_cnt !== 32'(exp_pkt) || stat_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL rmid_counters got pkt=%0d drop=%0d exp pkt=%0d drop=%0d", stat_pkt_cnt, stat_drop_cnt, exp_pkt, exp_drop); end
    endtask

    initial begin
        areset          = 1'b1;
        c_s_axis_tdata  = '0;
        c_s_axis_tkeep  = '0;
        c_s_axis_tuser  = '0;
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
        cfg_wr_ready    = 1'b1;
        test_reset();
        test_single();
        test_multi();
        test_partial();
        test_drop();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
